// File: rtl/parser_stream_arbiter_if.sv
// Character-stream handshake between one requester and the parser arbiter.
// Each beat carries one 7-bit ASCII character plus an end-of-program mark.
interface parser_stream_arbiter_if;
    logic [6:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/parser_stream_arbiter.sv
// Shares one if/else parser between two character-stream requesters.
// Whole programs are granted round-robin; the parser is cleared before each
// program and one tagged result is reported per program.
module parser_stream_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned DRAIN_CYCLES = 64,
    parameter logic [3:0]  TIMEOUT_CODE = 4'd15
) (
    input  logic                          clk,
    input  logic                          rst,
    parser_stream_arbiter_if.slave        req0,
    parser_stream_arbiter_if.slave        req1,
    output logic                          par_rst,
    output logic [6:0]                    par_char,
    output logic                          par_char_valid,
    input  logic                          par_done,
    input  logic                          par_error,
    input  logic [3:0]                    par_error_code,
    input  logic [31:0]                   par_p,
    input  logic [6:0]                    par_var,
    output logic                          res_valid,
    output logic                          res_id,
    output logic [31:0]                   res_p,
    output logic [6:0]                    res_var,
    output logic                          res_error,
    output logic [3:0]                    res_code,
    output logic                          busy,
    output logic                          grant_id
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned DrnW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StFlush,
        StDrain,
        StReport
    } state_e;

    // ------------------------------------------------------------------
    // Per-requester FIFOs, entry = {last, char}
    // ------------------------------------------------------------------
    logic [7:0]      mem_q    [2][FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q [2];
    logic [PtrW-1:0] rd_ptr_q [2];
    logic [CntW-1:0] cnt_q    [2];
    logic [7:0]      wdata    [2];
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      empty;
    logic [1:0]      full;
    logic            pop_req;
    logic [7:0]      head;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        clr_cnt_q, clr_cnt_d;
    logic [DrnW-1:0] drn_cnt_q, drn_cnt_d;
    logic [6:0]  par_char_q, par_char_d;
    logic        par_char_valid_q, par_char_valid_d;
    logic [31:0] cap_p_q, cap_p_d;
    logic [6:0]  cap_var_q, cap_var_d;
    logic        cap_error_q, cap_error_d;
    logic [3:0]  cap_code_q, cap_code_d;
    logic        res_id_q, res_id_d;
    logic [31:0] res_p_q, res_p_d;
    logic [6:0]  res_var_q, res_var_d;
    logic        res_error_q, res_error_d;
    logic [3:0]  res_code_q, res_code_d;

    assign wdata[0] = {req0.last, req0.data};
    assign wdata[1] = {req1.last, req1.data};

    // FIFO status flags and push/pop strobes
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CntW'(FIFO_DEPTH));
        end
        push[0] = req0.valid && !full[0];
        push[1] = req1.valid && !full[1];
        pop[0]  = pop_req && !grant_q;
        pop[1]  = pop_req && grant_q;
    end

    assign req0.ready = !full[0];
    assign req1.ready = !full[1];
    assign head       = mem_q[grant_q][rd_ptr_q[grant_q]];

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= wdata[i];
                    wr_ptr_q[i]           <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
                unique case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
                    2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    // Arbitration / streaming FSM next-state logic
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        clr_cnt_d        = clr_cnt_q;
        drn_cnt_d        = drn_cnt_q;
        par_char_d       = par_char_q;
        par_char_valid_d = 1'b0;
        pop_req          = 1'b0;
        cap_p_d          = cap_p_q;
        cap_var_d        = cap_var_q;
        cap_error_d      = cap_error_q;
        cap_code_d       = cap_code_q;
        res_id_d         = res_id_q;
        res_p_d          = res_p_q;
        res_var_d        = res_var_q;
        res_error_d      = res_error_q;
        res_code_d       = res_code_q;

        unique case (state_q)
            StIdle: begin
                if (!empty[0] || !empty[1]) begin
                    // Tie goes to whoever did not win last time
                    if (!empty[0] && !empty[1]) begin
                        grant_d = !last_grant_q;
                    end else begin
                        grant_d = empty[0];
                    end
                    last_grant_d = grant_d;
                    clr_cnt_d    = 1'b0;
                    state_d      = StClear;
                end
            end
            StClear: begin
                clr_cnt_d = 1'b1;
                if (clr_cnt_q) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (par_done || par_error) begin
                    // Parser finished early: freeze its result, discard the rest
                    cap_p_d     = par_p;
                    cap_var_d   = par_var;
                    cap_error_d = par_error;
                    cap_code_d  = par_error ? par_error_code : 4'd0;
                    state_d     = StFlush;
                end else if (!empty[grant_q]) begin
                    pop_req          = 1'b1;
                    par_char_d       = head[6:0];
                    par_char_valid_d = 1'b1;
                    if (head[7]) begin
                        drn_cnt_d = '0;
                        state_d   = StDrain;
                    end
                end
            end
            StFlush: begin
                if (!empty[grant_q]) begin
                    pop_req = 1'b1;
                    if (head[7]) begin
                        res_id_d    = grant_q;
                        res_p_d     = cap_p_q;
                        res_var_d   = cap_var_q;
                        res_error_d = cap_error_q;
                        res_code_d  = cap_code_q;
                        state_d     = StReport;
                    end
                end
            end
            StDrain: begin
                if (par_done || par_error) begin
                    res_id_d    = grant_q;
                    res_p_d     = par_p;
                    res_var_d   = par_var;
                    res_error_d = par_error;
                    res_code_d  = par_error ? par_error_code : 4'd0;
                    state_d     = StReport;
                end else if (drn_cnt_q == DrnW'(DRAIN_CYCLES - 1)) begin
                    res_id_d    = grant_q;
                    res_p_d     = par_p;
                    res_var_d   = par_var;
                    res_error_d = 1'b1;
                    res_code_d  = TIMEOUT_CODE;
                    state_d     = StReport;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, registered parser drive and captured results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            grant_q          <= 1'b0;
            last_grant_q     <= 1'b1;
            clr_cnt_q        <= 1'b0;
            drn_cnt_q        <= '0;
            par_char_q       <= '0;
            par_char_valid_q <= 1'b0;
            cap_p_q          <= '0;
            cap_var_q        <= '0;
            cap_error_q      <= 1'b0;
            cap_code_q       <= '0;
            res_id_q         <= 1'b0;
            res_p_q          <= '0;
            res_var_q        <= '0;
            res_error_q      <= 1'b0;
            res_code_q       <= '0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            last_grant_q     <= last_grant_d;
            clr_cnt_q        <= clr_cnt_d;
            drn_cnt_q        <= drn_cnt_d;
            par_char_q       <= par_char_d;
            par_char_valid_q <= par_char_valid_d;
            cap_p_q          <= cap_p_d;
            cap_var_q        <= cap_var_d;
            cap_error_q      <= cap_error_d;
            cap_code_q       <= cap_code_d;
            res_id_q         <= res_id_d;
            res_p_q          <= res_p_d;
            res_var_q        <= res_var_d;
            res_error_q      <= res_error_d;
            res_code_q       <= res_code_d;
        end
    end

    assign par_rst        = rst || (state_q == StClear);
    assign par_char       = par_char_q;
    assign par_char_valid = par_char_valid_q;
    assign res_valid      = (state_q == StReport);
    assign res_id         = res_id_q;
    assign res_p          = res_p_q;
    assign res_var        = res_var_q;
    assign res_error      = res_error_q;
    assign res_code       = res_code_q;
    assign busy           = (state_q != StIdle);
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_parser_stream_arbiter.sv
// Self-checking bench for parser_stream_arbiter: table of single-program
// vectors plus hand-written multi-program, reset and back-pressure sequences.
module tb_parser_stream_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parser_stream_arbiter_if r0 ();
    parser_stream_arbiter_if r1 ();

    logic        par_rst, par_char_valid, par_done, par_error;
    logic [6:0]  par_char, par_var;
    logic [3:0]  par_error_code;
    logic [31:0] par_p;
    logic        res_valid, res_id, res_error, busy, grant_id;
    logic [31:0] res_p;
    logic [6:0]  res_var;
    logic [3:0]  res_code;

    parser_stream_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (r0),
        .req1           (r1),
        .par_rst        (par_rst),
        .par_char       (par_char),
        .par_char_valid (par_char_valid),
        .par_done       (par_done),
        .par_error      (par_error),
        .par_error_code (par_error_code),
        .par_p          (par_p),
        .par_var        (par_var),
        .res_valid      (res_valid),
        .res_id         (res_id),
        .res_p          (res_p),
        .res_var        (res_var),
        .res_error      (res_error),
        .res_code       (res_code),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Parser model: mode 0 = done after cfg_len chars, 1 = error on char
    // cfg_err_at (visible while that char is presented), 2 = never finishes.
    int          cfg_mode   = 0;
    int          cfg_len    = 1;
    int          cfg_err_at = 1;
    logic [31:0] cfg_p      = '0;
    logic [6:0]  cfg_var    = '0;
    logic [3:0]  cfg_code   = '0;
    int          pm_cnt     = 0;
    logic        pm_done_q  = 1'b0;
    logic        pm_err_q   = 1'b0;

    always @(posedge clk) begin
        if (par_rst) begin
            pm_cnt    <= 0;
            pm_done_q <= 1'b0;
            pm_err_q  <= 1'b0;
        end else if (par_char_valid) begin
            pm_cnt <= pm_cnt + 1;
            if (cfg_mode == 0 && pm_cnt == cfg_len - 1) pm_done_q <= 1'b1;
            if (cfg_mode == 1 && pm_cnt == cfg_err_at - 1) pm_err_q <= 1'b1;
        end
    end

    assign par_done       = pm_done_q;
    assign par_error      = pm_err_q ||
                            (cfg_mode == 1 && par_char_valid && pm_cnt == cfg_err_at - 1);
    assign par_error_code = cfg_code;
    assign par_p          = cfg_p;
    assign par_var        = cfg_var;

    // Requester drivers: one queued entry {last,char} offered per cycle
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int pushes0 = 0;
    int pushes1 = 0;
    logic go0, go1;

    initial begin
        r0.valid = 1'b0; r0.data = '0; r0.last = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst && q0.size() > 0) begin
                r0.valid = 1'b1; r0.data = q0[0][6:0]; r0.last = q0[0][7]; go0 = r0.ready;
            end else begin
                r0.valid = 1'b0; go0 = 1'b0;
            end
            @(posedge clk);
            if (go0) begin void'(q0.pop_front()); pushes0++; end
        end
    end

    initial begin
        r1.valid = 1'b0; r1.data = '0; r1.last = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!rst && q1.size() > 0) begin
                r1.valid = 1'b1; r1.data = q1[0][6:0]; r1.last = q1[0][7]; go1 = r1.ready;
            end else begin
                r1.valid = 1'b0; go1 = 1'b0;
            end
            @(posedge clk);
            if (go1) begin void'(q1.pop_front()); pushes1++; end
        end
    end

    // Monitor: per-program char count, valid runs, clear length, drain gap
    typedef struct {
        logic        id;
        logic [31:0] p;
        logic [6:0]  v;
        logic        err;
        logic [3:0]  code;
        int          nvalid;
        int          runs;
        int          rstlen;
        int          gap;
    } rec_t;

    rec_t res_q[$];
    int   cyc = 0, nvalid = 0, runs = 0, rst_run = 0, rst_last = 0, last_valid_cyc = 0;
    logic pv_prev = 1'b0;

    function automatic rec_t mk_rec(logic id, logic [31:0] p, logic [6:0] v, logic err,
                                    logic [3:0] code, int nv, int rn, int rl, int gp);
        rec_t r;
        r.id = id; r.p = p; r.v = v; r.err = err; r.code = code;
        r.nvalid = nv; r.runs = rn; r.rstlen = rl; r.gap = gp;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (par_rst) begin
            rst_run <= rst_run + 1;
            nvalid  <= 0;
            runs    <= 0;
        end else begin
            if (rst_run != 0) rst_last <= rst_run;
            rst_run <= 0;
        end
        if (par_char_valid) begin
            nvalid         <= nvalid + 1;
            last_valid_cyc <= cyc;
            if (!pv_prev) runs <= runs + 1;
        end
        pv_prev <= par_char_valid;
        if (res_valid) begin
            res_q.push_back(mk_rec(res_id, res_p, res_var, res_error, res_code,
                                   nvalid, runs, rst_last, cyc - last_valid_cyc));
        end
    end

    task automatic load_prog(input int req, input string s, input bit with_last);
        logic [7:0] e;
        byte        b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            e = {(with_last && i == s.len() - 1), b[6:0]};
            if (req == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic wait_res(input int n, input int budget);
        int k = 0;
        while (res_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("result_count", res_q.size(), n);
    endtask

    task automatic set_rst(input logic v);
        @(negedge clk); #2;
        rst = v;
        if (v) begin
            q0.delete();
            q1.delete();
        end
    endtask

    typedef struct {
        int          req;
        string       prog;
        int          mode;
        int          err_at;
        logic [31:0] p;
        logic [6:0]  v;
        logic [3:0]  code;
        logic        exp_err;
        logic [3:0]  exp_code;
        int          exp_nvalid;
        int          exp_gap;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, "if ((x)<=(5)) begin a <= 73 ; endelse begin a <= 37 ; end", 0, 0,
                    32'd73, 7'h61, 4'd7, 1'b0, 4'd0, 57, 2};
        vecs[1] = '{1, "if (y) begin b <= 9 ; end", 0, 0,
                    32'hFFFF_FFFB, 7'h62, 4'd7, 1'b0, 4'd0, 25, 2};
        vecs[2] = '{0, "if (q)begin z<=4;end", 1, 5,
                    32'd5, 7'h7a, 4'd3, 1'b1, 4'd3, 5, -1};
        vecs[3] = '{0, "a <= 37 ;", 0, 0,
                    32'd37, 7'h61, 4'd0, 1'b0, 4'd0, 9, 2};
        vecs[4] = '{1, "if (z) a <= 1 ;", 2, 0,
                    32'd1234, 7'h63, 4'd9, 1'b1, 4'd15, 15, 64};
        vecs[5] = '{0, "if (((", 1, 1,
                    32'd0, 7'h00, 4'd12, 1'b1, 4'd12, 1, -1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_par_rst", par_rst, 1);
        chk("rst_ready0", r0.ready, 1);
        chk("rst_ready1", r1.ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_char_valid", par_char_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_res_p", res_p, 0);
        chk("rst_res_err", res_error, 0);
        chk("rst_res_code", res_code, 0);
        set_rst(1'b0);

        // Single-program vectors
        for (int i = 0; i < 6; i++) begin
            res_q.delete();
            cfg_mode   = vecs[i].mode;
            cfg_len    = vecs[i].exp_nvalid;
            cfg_err_at = vecs[i].err_at;
            cfg_p      = vecs[i].p;
            cfg_var    = vecs[i].v;
            cfg_code   = vecs[i].code;
            load_prog(vecs[i].req, vecs[i].prog, 1'b1);
            wait_res(1, 800);
            if (res_q.size() > 0) begin
                chk($sformatf("v%0d_id", i), res_q[0].id, vecs[i].req);
                chk($sformatf("v%0d_grant", i), grant_id, vecs[i].req);
                chk($sformatf("v%0d_p", i), res_q[0].p, vecs[i].p);
                chk($sformatf("v%0d_var", i), res_q[0].v, vecs[i].v);
                chk($sformatf("v%0d_err", i), res_q[0].err, vecs[i].exp_err);
                chk($sformatf("v%0d_code", i), res_q[0].code, vecs[i].exp_code);
                chk($sformatf("v%0d_nvalid", i), res_q[0].nvalid, vecs[i].exp_nvalid);
                chk($sformatf("v%0d_runs", i), res_q[0].runs, 1);
                chk($sformatf("v%0d_clear_len", i), res_q[0].rstlen, 2);
                if (vecs[i].exp_gap >= 0)
                    chk($sformatf("v%0d_gap", i), res_q[0].gap, vecs[i].exp_gap);
            end
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle", i), busy, 0);
            chk($sformatf("v%0d_res_hold", i), res_code, vecs[i].exp_code);
        end

        // Both requesters pending at reset release: 0 then 1
        cfg_mode = 0; cfg_len = 4; cfg_p = 32'd11; cfg_var = 7'h78; cfg_code = 4'd0;
        set_rst(1'b1);
        load_prog(0, "x<=1", 1'b1);
        load_prog(1, "y<=2", 1'b1);
        res_q.delete();
        set_rst(1'b0);
        wait_res(2, 400);
        if (res_q.size() >= 2) begin
            chk("tie_id0", res_q[0].id, 0);
            chk("tie_id1", res_q[1].id, 1);
            chk("tie_clear0", res_q[0].rstlen, 2);
            chk("tie_clear1", res_q[1].rstlen, 2);
            chk("tie_nvalid1", res_q[1].nvalid, 4);
        end

        // Three programs from 0, one from 1: grant order 0,1,0,0
        set_rst(1'b1);
        for (int k = 0; k < 3; k++) load_prog(0, "x<=1", 1'b1);
        load_prog(1, "y<=2", 1'b1);
        res_q.delete();
        set_rst(1'b0);
        wait_res(4, 600);
        if (res_q.size() >= 4) begin
            chk("rr_id0", res_q[0].id, 0);
            chk("rr_id1", res_q[1].id, 1);
            chk("rr_id2", res_q[2].id, 0);
            chk("rr_id3", res_q[3].id, 0);
        end

        // Stalled stream, full FIFO back-pressure, then reset mid-STREAM
        set_rst(1'b1);
        set_rst(1'b0);
        res_q.delete();
        cfg_mode = 2;
        load_prog(0, "if (", 1'b0);
        repeat (40) @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_no_res", res_q.size(), 0);
        chk("stall_char_valid", par_char_valid, 0);
        pushes1 = 0;
        load_prog(1, "abcdefghijklmnopq", 1'b1);
        repeat (30) @(negedge clk);
        chk("bp_pushes", pushes1, 16);
        chk("bp_ready1", r1.ready, 0);
        chk("bp_held", q1.size(), 1);
        set_rst(1'b1);
        @(negedge clk);
        chk("mid_rst_par_rst", par_rst, 1);
        chk("mid_rst_busy", busy, 0);
        set_rst(1'b0);
        repeat (10) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready0", r0.ready, 1);
        chk("post_rst_ready1", r1.ready, 1);
        chk("post_rst_par_rst", par_rst, 0);
        chk("post_rst_no_res", res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
